// File: rtl/pulse_period_meter_pkg.sv
// Shared types and constants for the pulse period meter.
package pulse_period_meter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SAT   = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_period_meter_edge_detect.sv
// Rising-edge detector for the measured pulse train.
// Define PULSE_METER_SYNC_EN to put a two-flop synchronizer in front of it.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_s;
  logic pulse_q;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], in};
  end

  assign in_s = sync_q[1];
`else
  assign in_s = in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_q <= 1'b0;
    else      pulse_q <= in_s;
  end

  assign rise = in_s & ~pulse_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive pulse rising edges, saturating at
// all-ones. PULSE_METER_SYNC_EN enables the input synchronizer in edge_detect.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             ovf,
  output logic             match
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             rise;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (pulse),
    .rise (rise)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (!en) begin
      // a rise in the same cycle as en dropping is deliberately lost
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = COUNT;
            cnt_d   = CNT_ONE;
          end
        end
        COUNT: begin
          if (rise) begin
            period_d = cnt_q;
            ovf_d    = 1'b0;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = SAT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        SAT: begin
          if (rise) begin
            period_d = CNT_MAX;
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            state_d  = COUNT;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    match_d = valid_d && (period_d == expected);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
    end
  end

  assign period = period_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign match  = match_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: a timestamp model of rise-to-rise
// intervals predicts each capture; the monitor pops and compares on valid.
module tb_pulse_period_meter;

  localparam int WIDTH = 8;
`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int             cyc;
    logic [WIDTH-1:0] per;
    logic           ovf;
    logic           mt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pulse;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             ovf;
  logic             match;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  logic [LAT+1:0] hist = '0;
  logic           armed = 1'b0;
  int             t1 = 0;

  pulse_period_meter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pulse    (pulse),
    .expected (expected),
    .period   (period),
    .valid    (valid),
    .ovf      (ovf),
    .match    (match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    hist  = '0;
    armed = 1'b0;
    q.delete();
  endtask

  // Predict captures from timestamps of detected rises (pulse delayed by LAT).
  task automatic model_step();
    logic rise_m;
    int   d;
    exp_t e;
    for (int k = LAT + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = pulse;
    if (!rst) begin
      model_reset();
      return;
    end
    rise_m = hist[LAT] & ~hist[LAT+1];
    if (!en) begin
      armed = 1'b0;
    end else if (rise_m) begin
      if (armed) begin
        d     = cyc - t1;
        e.cyc = cyc + 1;
        e.per = (d > 255) ? 8'd255 : d[WIDTH-1:0];
        e.ovf = (d > 255);
        e.mt  = (e.per == expected);
        q.push_back(e);
      end
      armed = 1'b1;
      t1    = cyc;
    end
  endtask

  task automatic drive(input logic p, input logic e, input logic r);
    @(posedge clk);
    #1;
    pulse = p;
    en    = e;
    rst   = r;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1);
  endtask

  task automatic pulse_train(input int per, input int n, input int hi);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < hi; j++)  drive(1'b1, 1'b1, 1'b1);
      for (int j = hi; j < per; j++) drive(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_period", period, 0);
    chk("rst_valid",  valid,  0);
    chk("rst_ovf",    ovf,    0);
    chk("rst_match",  match,  0);
    model_reset();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("valid_cyc", cyc, e.cyc);
          chk("period", period, e.per);
          chk("ovf", ovf, e.ovf);
          chk("match", match, e.mt);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("missed_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; pulse = 1'b0; expected = 8'd16;
    #2;
    chk("init_period", period, 0);
    chk("init_valid",  valid,  0);
    chk("init_ovf",    ovf,    0);
    chk("init_match",  match,  0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    idle(8);

    pulse_train(16, 3, 1);
    pulse_train(5, 3, 2);

    expected = 8'd255;
    pulse_train(300, 2, 1);
    pulse_train(10, 2, 1);
    pulse_train(255, 2, 1);
    pulse_train(256, 2, 1);
    expected = 8'd10;
    pulse_train(10, 2, 4);

    // en drop mid-count, then restore
    expected = 8'd12;
    pulse_train(12, 2, 1);
    drive(1'b1, 1'b1, 1'b1);
    idle(4);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
    idle(4);
    pulse_train(12, 3, 1);
    // rise coincident with en low is ignored
    drive(1'b1, 1'b0, 1'b1);
    idle(11);
    pulse_train(12, 3, 1);
    idle(20);

    do_reset();
    idle(5);
    pulse_train(9, 3, 1);
    idle(12);

    expected = 8'd7;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1);
    pulse_train(7, 5, 3);

    for (int i = 0; i < 12; i++) begin
      int per, hi;
      per = $urandom_range(2, 30);
      hi  = $urandom_range(1, per - 1);
      expected = 8'($urandom_range(2, 30));
      pulse_train(per, 2, hi);
      if (i % 4 == 3) drive(1'b0, 1'b0, 1'b1);
    end
    idle(10);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of the period counter, capture register and expected value.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: measurement enable; when low, the block returns to IDLE.
REQ-005 SHALL have port pulse, input, 1 bit: pulse train to be measured; only rising edges are significant.
REQ-006 SHALL have port expected, input, WIDTH bits: reference period in clk cycles.
REQ-007 SHALL have port period, output, WIDTH bits: last captured period.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle strobe marking a new period capture.
REQ-009 SHALL have port ovf, output, 1 bit: last capture saturated at 2^WIDTH-1.
REQ-010 SHALL have port match, output, 1 bit: asserted with valid when period equals expected.

Function
REQ-011 SHALL detect a rise when pulse is 1 in the current cycle and was 0 in the previous cycle (pulse_q register).
REQ-012 SHALL implement a three-state FSM: IDLE, COUNT and SAT.
REQ-013 IDLE: counter held at 0 and valid at 0; on a rise with en=1, the FSM SHALL go to COUNT with the counter loaded to 1.
REQ-014 COUNT: the counter SHALL increment by 1 per cycle.
REQ-015 COUNT, on a rise: period SHALL take the counter value, ovf SHALL be 0, valid SHALL be 1 in the next cycle, and the counter SHALL reload to 1.
REQ-016 COUNT, counter at 2^WIDTH-1 with no rise: the FSM SHALL enter SAT and the counter SHALL hold (no wrap-around).
REQ-017 SAT, on a rise: period SHALL be 2^WIDTH-1, ovf SHALL be 1, valid SHALL be 1 next cycle, the counter SHALL reload to 1, and the FSM SHALL return to COUNT.
REQ-018 The measured period SHALL equal the clk cycles between two consecutive detected rises (t2 - t1).
REQ-019 Capture-to-output latency SHALL be 1 cycle after the rise cycle.
REQ-020 valid SHALL be high for exactly one cycle per capture.
REQ-021 period and ovf SHALL hold their values until the next capture.
REQ-022 match SHALL equal valid AND (period == expected), registered together with valid.
REQ-023 en low SHALL force IDLE next cycle, abandon any partial count and suppress valid; period and ovf SHALL be retained.
REQ-024 A rise coincident with en going low SHALL be ignored.
REQ-025 A rise that arrives while pulse is held high SHALL count only once; the high level SHALL NOT retrigger.

Reset
REQ-026 While rst=0, the FSM SHALL be in IDLE and counter, pulse_q, period, valid, ovf and match SHALL all be 0, independent of clk.
REQ-027 Reset asserted mid-measurement SHALL discard the count.
REQ-028 After reset release, the first rise SHALL only arm the block; the first valid SHALL come at the second rise.

Configuration
REQ-029 Macro PULSE_METER_SYNC_EN defined: pulse SHALL pass through a two-flop synchronizer (reset to 0) before edge detection, adding 2 cycles to rise detection and valid timing; measured periods SHALL be unchanged.
REQ-030 Macro PULSE_METER_SYNC_EN undefined: pulse is synchronous to clk and SHALL feed edge detection directly.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, COUNT=2'd1, SAT=2'd2) and the default WIDTH constant.
REQ-032 Rise detection (plus the optional synchronizer) SHALL be one sub-module, edge_detect, with ports clk, rst, in, rise.

Verification
REQ-033 Reset, en=1, pulse rises at cycles 10, 26 and 42, expected=16 -> valid at cycles 27 and 43, period=16, match=1, ovf=0.
REQ-034 Period changes 16 -> 5, expected=16 -> second capture period=5, match=0.
REQ-035 WIDTH=8, rises 300 cycles apart -> SAT entered at count 255; on the rise period=255, ovf=1, valid=1; the following 10-cycle interval gives period=10, ovf=0.
REQ-036 en dropped for 3 cycles mid-count, then restored -> no valid for the interrupted interval; the next rise only arms; the following rise gives the correct period.
REQ-037 rst pulsed low between captures -> all outputs 0 immediately, without a clk edge; two further rises are needed for valid.
REQ-038 pulse held high for 20 cycles, then toggled at a 7-cycle period -> only rising edges are counted, period=7; with PULSE_METER_SYNC_EN defined, valid is 2 cycles later and the same values result.
